// File: rtl/vote_link_n_if.sv
// Peer link of the voting terminal: frame buses plus the rts/rtr/cts/ctr handshake.
interface vote_link_n_if #(
  parameter int NV = 3
);
  logic        rts;
  logic        rtr;
  logic [NV:0] v_in;
  logic [NV:0] v_out;
  logic        cts;
  logic        ctr;

  // Four-phase handshake, one round: terminal raises cts with v_out valid, peer drops rts,
  // terminal raises ctr, peer raises rts with v_in valid, terminal drops ctr, peer drops rtr,
  // terminal drops cts. Neither side moves until it has seen the other side's previous edge.
  modport master (input rts, rtr, v_in, output v_out, cts, ctr);
  modport slave  (output rts, rtr, v_in, input v_out, cts, ctr);
endinterface

// File: rtl/vote_link_n.sv
// Voting-terminal link controller: collects an NV-bit vote, appends even parity and trades
// frames with a peer. Optional receive parity check: define VOTE_LINK_PARITY_CHECK_EN.
module vote_link_n #(
  parameter int            NV         = 3,
  parameter int            MAX_ROUNDS = 4,
  parameter int            TIMEOUT    = 15,
  parameter logic [NV-1:0] TERM_CODE  = NV'(3'b110)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          key,
  input  logic          test,
  input  logic [NV-2:0] button,
  output logic          busy,
  output logic          err,
  output logic [3:0]    dbg_state_o,
  vote_link_n_if.master link
);

  // Encoding is fixed so the debug port is stable across builds.
  typedef enum logic [3:0] {
    ST_STARTUP  = 4'd0,
    ST_STANDBY  = 4'd1,
    ST_GET_IN   = 4'd2,
    ST_START_TX = 4'd3,
    ST_SEND     = 4'd4,
    ST_TX_2_RX  = 4'd5,
    ST_RECEIVE  = 4'd6,
    ST_RX_2_TX  = 4'd7,
    ST_END_TX   = 4'd8,
    ST_TEST_1   = 4'd9,
    ST_TEST_2   = 4'd10,
    ST_ERROR    = 4'd11
  } state_t;

  state_t        state_q, state_d;
  logic [NV-1:0] data_q, data_d;
  logic          parity_q, parity_d;
  logic [NV-2:0] last_btn_q, last_btn_d;
  logic [7:0]    rounds_q, rounds_d;
  logic [7:0]    timer_q, timer_d;
  logic [NV:0]   v_out_q, v_out_d;
  logic          cts_q, cts_d;
  logic          ctr_q, ctr_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          timeout;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_STARTUP;
      data_q     <= '0;
      parity_q   <= 1'b0;
      last_btn_q <= '0;
      rounds_q   <= '0;
      timer_q    <= '0;
      v_out_q    <= '0;
      cts_q      <= 1'b0;
      ctr_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      last_btn_q <= last_btn_d;
      rounds_q   <= rounds_d;
      timer_q    <= timer_d;
      v_out_q    <= v_out_d;
      cts_q      <= cts_d;
      ctr_q      <= ctr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    parity_d   = parity_q;
    last_btn_d = last_btn_q;
    rounds_d   = rounds_q;
    v_out_d    = v_out_q;
    cts_d      = cts_q;
    ctr_d      = ctr_q;
    err_d      = err_q;
    timeout    = (timer_q == 8'(TIMEOUT));

    case (state_q)
      ST_STARTUP: begin
        data_d  = '0;
        cts_d   = 1'b0;
        ctr_d   = 1'b0;
        state_d = test ? ST_STANDBY : ST_TEST_1;
      end
      ST_STANDBY: begin
        cts_d = link.rtr;
        if (start) begin
          data_d  = '0;
          err_d   = 1'b0;
          state_d = ST_GET_IN;
        end
      end
      ST_GET_IN: begin
        last_btn_d = button;
        // Commit takes priority: a button edge in the commit cycle is dropped.
        if (!start) begin
          state_d = ST_START_TX;
        end else if (key) begin
          data_d[0]    = 1'b1;
          data_d[NV-1:1] = data_q[NV-1:1] ^ (button & ~last_btn_q);
        end else begin
          data_d = '0;
        end
      end
      ST_START_TX: begin
        parity_d = ^data_q;
        rounds_d = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (link.rtr) begin
          v_out_d = {parity_q, data_q};
          cts_d   = 1'b1;
          if (data_q == TERM_CODE) begin
            state_d = ST_END_TX;
          end else if (rounds_q == 8'(MAX_ROUNDS - 1)) begin
            state_d = ST_END_TX;
            err_d   = 1'b1;
          end else begin
            rounds_d = rounds_q + 8'd1;
            state_d  = ST_TX_2_RX;
          end
        end
      end
      ST_TX_2_RX: begin
        if (!link.rts) begin
          ctr_d   = 1'b1;
          state_d = ST_RECEIVE;
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_RECEIVE: begin
        if (link.rts) begin
          {parity_d, data_d} = link.v_in;
          ctr_d   = 1'b0;
          state_d = ST_RX_2_TX;
`ifdef VOTE_LINK_PARITY_CHECK_EN
          if (link.v_in[NV] != ^link.v_in[NV-1:0]) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
`else
`endif
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_RX_2_TX: begin
        if (!link.rtr) begin
          cts_d   = 1'b0;
          state_d = ST_SEND;
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_END_TX: begin
        if (!link.rtr) begin
          cts_d   = 1'b0;
          state_d = ST_STANDBY;
        end else if (timeout) begin
          state_d = ST_ERROR;
        end
      end
      ST_TEST_1: begin
        {parity_d, data_d} = link.v_in;
        if (&{parity_q, data_q}) state_d = ST_TEST_2;
      end
      ST_TEST_2: begin
        data_d[0] = ~data_q[0];
        state_d   = ST_SEND;
      end
      ST_ERROR: begin
        if (!start && !link.rtr) state_d = ST_STANDBY;
      end
      default: state_d = ST_STARTUP;
    endcase

    // Error outputs appear on the same edge that enters ERROR.
    if (state_d == ST_ERROR) begin
      cts_d = 1'b0;
      ctr_d = 1'b0;
      err_d = 1'b1;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q inside {ST_TX_2_RX, ST_RECEIVE, ST_RX_2_TX, ST_END_TX}) begin
      timer_d = timer_q + 8'd1;
    end else begin
      timer_d = '0;
    end

    busy_d = (state_d != ST_STANDBY) && (state_d != ST_STARTUP);
  end

  assign link.v_out  = v_out_q;
  assign link.cts    = cts_q;
  assign link.ctr    = ctr_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
